// File: rtl/bin_to_bcd_8digit_pkg.sv
// Shared definitions for the 8-digit binary-to-BCD converter:
// default sizes, FSM state encoding, blank digit code and decimal limit.
package bin_to_bcd_8digit_pkg;

    localparam int BIN_W_DEF  = 27;
    localparam int DIGITS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Code the 7-seg decoder renders as an unlit digit
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Largest value representable with the given number of decimal digits
    function automatic logic [63:0] max_dec(input int digits);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < digits; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = max_dec(DIGITS_DEF);

endpackage

// File: rtl/bin_to_bcd_8digit_if.sv
// Start/busy/done handshake and data bus of the binary-to-BCD converter.
// master drives requests, slave is the converter.
interface bin_to_bcd_8digit_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (output start, bin_in, input busy, done, bcd_out, overflow);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bin_to_bcd_8digit_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);
    // Pure combinational correction
    always_comb begin
        out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;
    end
endmodule

// File: rtl/bin_to_bcd_8digit.sv
// Sequential double-dabble converter: binary input -> DIGITS packed BCD digits.
// One bit is shifted in per cycle; the result register only changes at the
// end of a conversion, so the display never sees partial values.
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits above digit0 are
// output as the blank code instead of 4'h0.
module bin_to_bcd_8digit
    import bin_to_bcd_8digit_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    bin_to_bcd_8digit_if.slave     bus
);
    localparam int          CNT_W   = $clog2(BIN_W);
    localparam int          SR_W    = 4*DIGITS + BIN_W;
    localparam logic [63:0] MAX_VAL = max_dec(DIGITS);

    state_e                state_q;
    logic [BIN_W-1:0]      shift_q;
    logic [4*DIGITS-1:0]   scratch_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ovf_flag_q;
    logic                  busy_q;
    logic                  done_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  ovf_q;

    logic [4*DIGITS-1:0]   adj;
    logic [SR_W-1:0]       joint_d;
    logic [4*DIGITS-1:0]   scratch_d;
    logic [BIN_W-1:0]      shift_d;
    logic [4*DIGITS-1:0]   result_d;
    logic                  ovf_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_i  (scratch_q[4*g +: 4]),
            .out_o (adj[4*g +: 4])
        );
    end

    // One double-dabble step: corrected digits and remaining binary shift left together
    always_comb begin
        joint_d   = {adj, shift_q} << 1;
        scratch_d = joint_d[SR_W-1 -: 4*DIGITS];
        shift_d   = joint_d[BIN_W-1:0];
    end

    // Capture-time range check; wider than any input so no bits are lost
    always_comb begin
        ovf_d = ({{(64-BIN_W){1'b0}}, bus.bin_in} > MAX_VAL);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
`endif

    // Final presented value: saturated on overflow, optionally blanked
    always_comb begin
        result_d = scratch_q;
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = DIGITS-1; i > 0; i--) begin
            if (lead && scratch_q[4*i +: 4] == 4'h0) result_d[4*i +: 4] = BCD_BLANK;
            else                                     lead = 1'b0;
        end
`endif
        if (ovf_flag_q) result_d = {DIGITS{4'h9}};
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        shift_q    <= bus.bin_in;
                        scratch_q  <= '0;
                        cnt_q      <= CNT_W'(BIN_W-1);
                        ovf_flag_q <= ovf_d;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    if (cnt_q == '0) state_q <= ST_DONE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_DONE: begin
                    bcd_q   <= result_d;
                    ovf_q   <= ovf_flag_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_8digit.sv
// Self-checking bench for bin_to_bcd_8digit: directed corner cases plus
// random values compared against a decimal arithmetic reference model.
module tb_bin_to_bcd_8digit;

    localparam int BIN_W   = 27;
    localparam int LAT     = BIN_W + 2;   // negedge samples after the start edge until done
    localparam int MAXWAIT = 80;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bin_to_bcd_8digit_if #(.BIN_W(BIN_W), .DIGITS(8)) bus ();

    bin_to_bcd_8digit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by division; saturate above 8 digits
    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        bit lead;
        if (v > 32'd99_999_999) return 32'h9999_9999;
        x = v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = 7; i > 0; i--) begin
            if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
        if (lead) r = '0;
`endif
        return r;
    endfunction

    // Drive one start and follow the conversion until done (bounded).
    // lat = negedge sample index at which done was seen (0 = never).
    task automatic run_conv(input int unsigned v, input bit at_negedge,
                            output logic [31:0] got, output logic ovf,
                            output int busy_cnt, output int done_cnt,
                            output int lat, output int held_bad);
        logic [31:0] prev;
        logic [31:0] val;
        if (!at_negedge) @(negedge clk);
        val = v;
        bus.start  = 1'b1;
        bus.bin_in = val[BIN_W-1:0];
        prev = bus.bcd_out;
        busy_cnt = 0; done_cnt = 0; lat = 0; held_bad = 0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= MAXWAIT; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                lat = k;
                break;
            end
            if (bus.bcd_out !== prev) held_bad++;
        end
        got = bus.bcd_out;
        ovf = bus.overflow;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.bin_in = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.bcd_out !== 32'h0) begin errors++; $display("FAIL reset_bcd got %h want 0", bus.bcd_out); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        reset = 1'b0;
    endtask

    task automatic test_zero();
        logic [31:0] got; logic ovf; int bc, dc, lat, hb;
        run_conv(0, 1'b0, got, ovf, bc, dc, lat, hb);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, LAT); end
        checks++; if (got !== ref_bcd(0)) begin errors++; $display("FAIL zero_bcd got %h want %h", got, ref_bcd(0)); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf got %b want 0", ovf); end
    endtask

    task automatic test_known();
        logic [31:0] got; logic ovf; int bc, dc, lat, hb;
        run_conv(12_345_678, 1'b0, got, ovf, bc, dc, lat, hb);
        checks++; if (got !== 32'h1234_5678) begin errors++; $display("FAIL known_bcd got %h want 12345678", got); end
        checks++; if (bc !== BIN_W + 1) begin errors++; $display("FAIL known_busy_cycles got %0d want %0d", bc, BIN_W + 1); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL known_done_count got %0d want 1", dc); end
        checks++; if (hb !== 0) begin errors++; $display("FAIL known_held got %0d changes want 0", hb); end
        // done must be a single-cycle pulse with busy already low
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL known_pulse got done=%b busy=%b want 0 0", bus.done, bus.busy); end
        checks++; if (bus.bcd_out !== 32'h1234_5678) begin errors++; $display("FAIL known_hold got %h want 12345678", bus.bcd_out); end
    endtask

    task automatic test_limits();
        logic [31:0] got; logic ovf; int bc, dc, lat, hb;
        int unsigned vals [3];
        vals[0] = 99_999_999; vals[1] = 100_000_000; vals[2] = 134_217_727;
        foreach (vals[i]) begin
            run_conv(vals[i], 1'b0, got, ovf, bc, dc, lat, hb);
            checks++; if (got !== ref_bcd(vals[i])) begin
                errors++; $display("FAIL limit_bcd v=%0d got %h want %h", vals[i], got, ref_bcd(vals[i])); end
            checks++; if (ovf !== (vals[i] > 99_999_999)) begin
                errors++; $display("FAIL limit_ovf v=%0d got %b want %b", vals[i], ovf, vals[i] > 99_999_999); end
        end
    endtask

    task automatic test_ignore_start();
        int dc, lat, bc;
        logic [31:0] v;
        v = 32'd31_415_926;
        @(negedge clk);
        bus.start = 1'b1; bus.bin_in = v[BIN_W-1:0];
        @(posedge clk);
        #1 bus.start = 1'b0;
        dc = 0; lat = 0; bc = 0;
        for (int k = 1; k <= MAXWAIT; k++) begin
            @(negedge clk);
            if (k == 6) begin bus.start = 1'b1; bus.bin_in = 27'd5; end
            if (k == 7) bus.start = 1'b0;
            if (k == LAT - 1) begin bus.start = 1'b1; bus.bin_in = 27'd9; end  // during DONE state
            if (k == LAT) bus.start = 1'b0;
            if (bus.done) begin dc++; if (lat == 0) lat = k; end
            if (k >= LAT + 2 * BIN_W) break;
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dc); end
        checks++; if (bus.bcd_out !== ref_bcd(v)) begin errors++; $display("FAIL ignore_bcd got %h want %h", bus.bcd_out, ref_bcd(v)); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] got; logic ovf; int bc, dc, lat, hb, dseen;
        @(negedge clk);
        bus.start = 1'b1; bus.bin_in = 27'd4321;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", bus.done); end
        checks++; if (bus.bcd_out !== 32'h0) begin errors++; $display("FAIL abort_bcd got %h want 0", bus.bcd_out); end
        dseen = 0;
        for (int k = 0; k < BIN_W + 10; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dseen++;
        end
        checks++; if (dseen !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", dseen); end
        run_conv(7, 1'b0, got, ovf, bc, dc, lat, hb);
        checks++; if (got !== ref_bcd(7)) begin errors++; $display("FAIL abort_restart got %h want %h", got, ref_bcd(7)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got; logic ovf; int bc, dc, lat, hb;
        run_conv(2_024, 1'b0, got, ovf, bc, dc, lat, hb);
        // start driven while done is high: must be accepted immediately
        run_conv(87_654_321, 1'b1, got, ovf, bc, dc, lat, hb);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        checks++; if (got !== ref_bcd(87_654_321)) begin errors++; $display("FAIL b2b_bcd got %h want %h", got, ref_bcd(87_654_321)); end
    endtask

    task automatic test_random();
        logic [31:0] got; logic ovf; int bc, dc, lat, hb;
        int unsigned v;
        for (int n = 0; n < 24; n++) begin
            case (n % 3)
                0: v = $urandom_range(0, 999);
                1: v = $urandom_range(0, 99_999_999);
                default: v = $urandom_range(0, 134_217_727);
            endcase
            run_conv(v, (n % 4) == 3, got, ovf, bc, dc, lat, hb);
            checks++; if (got !== ref_bcd(v) || ovf !== (v > 99_999_999) || dc !== 1) begin
                errors++;
                $display("FAIL random v=%0d got %h ovf=%b done=%0d want %h ovf=%b done=1",
                         v, got, ovf, dc, ref_bcd(v), v > 99_999_999);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; bus.start = 1'b0; bus.bin_in = '0;
        test_reset();
        test_zero();
        test_known();
        test_limits();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
